// File: rtl/mii_tx_nibble_framer.sv
// MII transmit framer: preamble/SFD, byte-stream payload as nibbles, optional
// zero padding, CRC-32 FCS and an enforced inter-frame gap. All outputs registered.
module mii_tx_nibble_framer #(
    parameter int PAD_EN     = 1,
    parameter int MIN_BYTES  = 60,
    parameter int IFG_CYCLES = 24
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [3:0] mii_txd,
    output logic       mii_tx_en,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG} state_t;

    localparam logic [31:0] POLY     = 32'hEDB88320;
    localparam logic [15:0] MIN_CNT  = 16'(MIN_BYTES);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] byte_cnt, byte_cnt_n;
    logic [7:0]  cur_byte, cur_byte_n;
    logic        last, last_n;
    logic [31:0] crc, crc_n, crc_upd, fcs;
    logic        s_ready_n, tx_en_n, busy_n, underrun_n;
    logic [3:0]  txd_n;

    function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] r;
        r = c ^ {28'h0, n};
        for (int unsigned i = 0; i < 4; i++)
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v >= MIN_CNT) ? v : v + 16'd1;
    endfunction

    // mii_txd holds the nibble on the wire this cycle, so it feeds the CRC directly.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        byte_cnt_n = byte_cnt;
        cur_byte_n = cur_byte;
        last_n     = last;
        underrun_n = 1'b0;
        crc_upd    = crc_nibble(crc, mii_txd);
        crc_n      = crc;

        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_n    = PRE;
                    cnt_n      = '0;
                    byte_cnt_n = '0;
                end
            end
            PRE: begin
                if (cnt == 16'd15) begin
                    cnt_n = '0;
                    if (s_valid) begin
                        state_n    = DATA;
                        cur_byte_n = s_data;
                        last_n     = s_last;
                        byte_cnt_n = sat_inc(byte_cnt);
                    end else begin
                        state_n    = IFG;
                        underrun_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                crc_n = crc_upd;
                if (!cnt[0]) begin
                    cnt_n = 16'd1;
                end else begin
                    cnt_n = '0;
                    if (last) begin
                        if (PAD_EN != 0 && byte_cnt < MIN_CNT) begin
                            state_n    = PAD;
                            byte_cnt_n = sat_inc(byte_cnt);
                        end else begin
                            state_n = FCS;
                        end
                    end else if (s_valid) begin
                        cur_byte_n = s_data;
                        last_n     = s_last;
                        byte_cnt_n = sat_inc(byte_cnt);
                    end else begin
                        state_n    = IFG;
                        underrun_n = 1'b1;
                    end
                end
            end
            PAD: begin
                crc_n = crc_upd;
                if (!cnt[0]) begin
                    cnt_n = 16'd1;
                end else begin
                    cnt_n = '0;
                    if (byte_cnt >= MIN_CNT) state_n = FCS;
                    else byte_cnt_n = sat_inc(byte_cnt);
                end
            end
            FCS: begin
                if (cnt == 16'd7) begin
                    state_n = IFG;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n == IFG && state != IFG) crc_n = '1;

        // Outputs are derived from the next state so the registers line up with it.
        fcs       = ~crc_n;
        tx_en_n   = (state_n == PRE) || (state_n == DATA) || (state_n == PAD) || (state_n == FCS);
        busy_n    = (state_n != IDLE);
        s_ready_n = (state_n == PRE && cnt_n == 16'd15) || (state_n == DATA && cnt_n[0] && !last_n);
        case (state_n)
            PRE:     txd_n = (cnt_n == 16'd15) ? 4'hD : 4'h5;
            DATA:    txd_n = cnt_n[0] ? cur_byte_n[7:4] : cur_byte_n[3:0];
            FCS:     txd_n = fcs[{cnt_n[2:0], 2'b00} +: 4];
            default: txd_n = '0;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            byte_cnt  <= '0;
            cur_byte  <= '0;
            last      <= 1'b0;
            crc       <= '1;
            s_ready   <= 1'b0;
            mii_txd   <= '0;
            mii_tx_en <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            byte_cnt  <= byte_cnt_n;
            cur_byte  <= cur_byte_n;
            last      <= last_n;
            crc       <= crc_n;
            s_ready   <= s_ready_n;
            mii_txd   <= txd_n;
            mii_tx_en <= tx_en_n;
            busy      <= busy_n;
            underrun  <= underrun_n;
        end
    end

endmodule

// File: tb/tb_mii_tx_nibble_framer.sv
// Bench for mii_tx_nibble_framer: one unpadded and one padded instance, a
// byte-level CRC reference model and a nibble scoreboard.
module tb_mii_tx_nibble_framer;

    typedef logic [7:0] bq_t[$];
    typedef logic [8:0] sq_t[$];

    typedef struct {
        int d;
        int seed;
        int len;
        int drop;
        int exp_hi;
        int exp_ur;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data    [2];
    logic       s_valid   [2];
    logic       s_last    [2];
    logic       s_ready   [2];
    logic [3:0] mii_txd   [2];
    logic       mii_tx_en [2];
    logic       busy      [2];
    logic       underrun  [2];

    always #20 clk = ~clk;

    mii_tx_nibble_framer #(.PAD_EN(0), .MIN_BYTES(60), .IFG_CYCLES(24)) u_nopad (
        .clk_in(clk), .reset(reset), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_last(s_last[0]), .s_ready(s_ready[0]), .mii_txd(mii_txd[0]),
        .mii_tx_en(mii_tx_en[0]), .busy(busy[0]), .underrun(underrun[0]));

    mii_tx_nibble_framer #(.PAD_EN(1), .MIN_BYTES(60), .IFG_CYCLES(24)) u_pad (
        .clk_in(clk), .reset(reset), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_last(s_last[1]), .s_ready(s_ready[1]), .mii_txd(mii_txd[1]),
        .mii_tx_en(mii_tx_en[1]), .busy(busy[1]), .underrun(underrun[1]));

    // Monitor: captures wire nibbles, run lengths of mii_tx_en, s_ready positions.
    logic [3:0] cap     [2][8192];
    int         wp      [2] = '{0, 0};
    int         hi_runs [2][64];
    int         lo_runs [2][64];
    int         nh      [2] = '{0, 0};
    int         nl      [2] = '{0, 0};
    int         run_cnt [2] = '{0, 0};
    int         rdy_pos [2][512];
    int         nr      [2] = '{0, 0};
    int         ur_cnt  [2] = '{0, 0};
    logic       prev_en [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mii_tx_en[d]) begin
                cap[d][wp[d] % 8192] <= mii_txd[d];
                wp[d] <= wp[d] + 1;
            end
            if (mii_tx_en[d] != prev_en[d]) begin
                if (mii_tx_en[d]) begin
                    lo_runs[d][nl[d] % 64] <= run_cnt[d];
                    nl[d] <= nl[d] + 1;
                end else begin
                    hi_runs[d][nh[d] % 64] <= run_cnt[d];
                    nh[d] <= nh[d] + 1;
                end
                run_cnt[d] <= 1;
            end else begin
                run_cnt[d] <= run_cnt[d] + 1;
            end
            if (s_ready[d]) begin
                rdy_pos[d][nr[d] % 512] <= !mii_tx_en[d] ? -1 : (prev_en[d] ? run_cnt[d] : 0);
                nr[d] <= nr[d] + 1;
            end
            if (underrun[d]) ur_cnt[d] <= ur_cnt[d] + 1;
            prev_en[d] <= mii_tx_en[d];
        end
    end

    int         vectors = 0;
    int         fails   = 0;
    int         rp [2]  = '{0, 0};
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic bq_t gen(input int seed, input int len);
        bq_t b;
        for (int i = 0; i < len; i++)
            b.push_back((seed == 0) ? 8'(8'h31 + i) : 8'(seed * 37 + i * 11 + i * i));
        return b;
    endfunction

    task automatic push_frame(input bq_t b, input bit pad, input int nsent, input bit with_fcs);
        logic [31:0] c;
        logic [31:0] f;
        int          n;
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        for (int i = 0; i < nsent; i++) begin
            exp_q.push_back(b[i][3:0]);
            exp_q.push_back(b[i][7:4]);
        end
        if (with_fcs) begin
            c = '1;
            foreach (b[i]) c = crc_byte(c, b[i]);
            n = b.size();
            while (pad && n < 60) begin
                c = crc_byte(c, 8'h00);
                exp_q.push_back(4'h0);
                exp_q.push_back(4'h0);
                n++;
            end
            f = ~c;
            for (int k = 0; k < 8; k++) exp_q.push_back(f[4*k +: 4]);
        end
    endtask

    task automatic drain(input int d);
        logic [3:0] e;
        while (exp_q.size() > 0) begin
            if (rp[d] >= wp[d]) begin
                chk("nibble count", wp[d] - rp[d], exp_q.size());
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            chk("nibble", int'(cap[d][rp[d] % 8192]), int'(e));
            rp[d]++;
        end
        if (rp[d] < wp[d]) chk("extra nibbles", wp[d] - rp[d], 0);
        rp[d] = wp[d];
    endtask

    // Presents a {last,data} stream; drop_at lowers s_valid in that byte's fetch
    // slot, stop_after returns (s_valid still high) once that many bytes are taken.
    task automatic drive(input int d, input sq_t st, input int drop_at, input int stop_after);
        int idx   = 0;
        int guard = 0;
        s_data[d]  = st[0][7:0];
        s_last[d]  = st[0][8];
        s_valid[d] = 1'b1;
        while (idx < st.size() && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (s_ready[d]) begin
                if (idx == drop_at) begin
                    s_valid[d] = 1'b0;
                    s_last[d]  = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
                idx++;
                if (idx == stop_after) return;
                if (idx < st.size()) begin
                    s_data[d] = st[idx][7:0];
                    s_last[d] = st[idx][8];
                end else begin
                    s_valid[d] = 1'b0;
                    s_last[d]  = 1'b0;
                    s_data[d]  = '0;
                end
            end
        end
        if (guard >= 5000) begin
            chk("drive timeout bytes taken", idx, st.size());
            s_valid[d] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d, output int ifg);
        int g = 0;
        ifg = 0;
        while (busy[d] && g < 3000) begin
            @(negedge clk);
            g++;
            if (busy[d] && !mii_tx_en[d]) ifg++;
        end
        chk("busy timeout", int'(busy[d]), 0);
        @(negedge clk);
    endtask

    task automatic run_frame(input int d, input int seed, input int len, input int drop,
                             input int exp_hi, input int exp_ur);
        bq_t b;
        sq_t st;
        int  nh0, ur0, ifg;
        b = gen(seed, len);
        foreach (b[i]) st.push_back({(i == len - 1), b[i]});
        nh0 = nh[d];
        ur0 = ur_cnt[d];
        push_frame(b, d == 1, (drop < 0) ? len : drop, drop < 0);
        drive(d, st, drop, -1);
        wait_idle(d, ifg);
        chk("tx_en high cycles", hi_runs[d][nh0 % 64], exp_hi);
        chk("tx_en bursts", nh[d] - nh0, 1);
        chk("underrun pulses", ur_cnt[d] - ur0, exp_ur);
        chk("ifg busy cycles", ifg, 24);
        drain(d);
    endtask

    vec_t tbl[9];
    int   fcs_ref[8] = '{6, 2, 9, 3, 4, 15, 11, 12};

    initial begin
        int  base, nr0, nh0, ifg;
        bq_t b1, b2;
        sq_t st;

        tbl[0] = '{0, 0,  9, -1,  42, 0};
        tbl[1] = '{1, 1, 10, -1, 144, 0};
        tbl[2] = '{1, 2, 12,  4,  24, 1};
        tbl[3] = '{1, 3, 60, -1, 144, 0};
        tbl[4] = '{1, 4, 61, -1, 146, 0};
        tbl[5] = '{0, 5,  1, -1,  26, 0};
        tbl[6] = '{1, 6, 59, -1, 144, 0};
        tbl[7] = '{0, 7,  1,  0,  16, 1};
        tbl[8] = '{0, 8, 64, -1, 152, 0};

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0;
            s_last[d]  = 1'b0;
            s_data[d]  = '0;
        end
        #5;
        for (int d = 0; d < 2; d++) begin
            chk("reset mii_tx_en", int'(mii_tx_en[d]), 0);
            chk("reset mii_txd", int'(mii_txd[d]), 0);
            chk("reset s_ready", int'(s_ready[d]), 0);
            chk("reset busy", int'(busy[d]), 0);
            chk("reset underrun", int'(underrun[d]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[i])
            run_frame(tbl[i].d, tbl[i].seed, tbl[i].len, tbl[i].drop, tbl[i].exp_hi, tbl[i].exp_ur);

        // Known FCS of "123456789" and s_ready slot positions.
        base = wp[0];
        nr0  = nr[0];
        run_frame(0, 0, 9, -1, 42, 0);
        for (int k = 0; k < 8; k++) chk("fcs nibble", int'(cap[0][(base + 34 + k) % 8192]), fcs_ref[k]);
        chk("s_ready pulses", nr[0] - nr0, 9);
        for (int i = 0; i < 9; i++) chk("s_ready position", rdy_pos[0][(nr0 + i) % 512], 15 + 2 * i);

        // Back-to-back frames with s_valid held across the gap.
        b1 = gen(0, 9);
        b2 = gen(9, 9);
        st.delete();
        foreach (b1[i]) st.push_back({(i == 8), b1[i]});
        foreach (b2[i]) st.push_back({(i == 8), b2[i]});
        push_frame(b1, 1'b0, 9, 1'b1);
        push_frame(b2, 1'b0, 9, 1'b1);
        nh0 = nh[0];
        drive(0, st, -1, -1);
        wait_idle(0, ifg);
        chk("b2b bursts", nh[0] - nh0, 2);
        chk("b2b first burst", hi_runs[0][nh0 % 64], 42);
        chk("b2b second burst", hi_runs[0][(nh0 + 1) % 64], 42);
        chk("b2b gap cycles", lo_runs[0][(nl[0] - 1) % 64], 25);
        drain(0);

        // Asynchronous reset in a DATA high-nibble cycle.
        st.delete();
        b1 = gen(0, 9);
        foreach (b1[i]) st.push_back({(i == 8), b1[i]});
        drive(0, st, -1, 3);
        @(posedge clk);
        #10;
        chk("pre-reset mii_tx_en", int'(mii_tx_en[0]), 1);
        chk("pre-reset s_ready", int'(s_ready[0]), 1);
        chk("pre-reset busy", int'(busy[0]), 1);
        reset = 1'b1;
        #1;
        chk("async reset mii_tx_en", int'(mii_tx_en[0]), 0);
        chk("async reset s_ready", int'(s_ready[0]), 0);
        chk("async reset busy", int'(busy[0]), 0);
        s_valid[0] = 1'b0;
        s_last[0]  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rp[0] = wp[0];
        run_frame(0, 0, 9, -1, 42, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/mii_tx_nibble_framer.md
Name: mii_tx_nibble_framer

Overview:
- Ethernet MII transmit framer clocked by the 25 MHz clock from the clock divider.
- Accepts frame bytes over a valid/ready stream from the UDP/IP packet builder.
- Drives the PHY MII TX pins, one nibble per clock, with:
  - preamble and SFD prepended;
  - optional padding to minimum size;
  - CRC-32 FCS appended;
  - inter-frame gap enforced.

Parameters:
- PAD_EN, 1, 1 = zero-pad payload to MIN_BYTES before FCS; 0 = no padding.
- MIN_BYTES, 60, minimum data+pad byte count when PAD_EN=1; excludes FCS.
- IFG_CYCLES, 24, idle clocks with mii_tx_en low after the FCS; 24 = 12 byte times.

Ports:
- clk_in  in  1  25 MHz MII TX clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- s_data  in  8  frame byte: destination MAC first, no preamble, no FCS.
- s_valid  in  1  s_data/s_last valid; must stay high within a frame until s_last is accepted.
- s_last  in  1  marks the final byte of the frame.
- s_ready  out  1  byte accepted on a clk_in edge where s_valid & s_ready.
- mii_txd  out  4  MII transmit nibble, LSB nibble of each byte first.
- mii_tx_en  out  1  MII transmit enable.
- busy  out  1  high from frame start through the end of the IFG.
- underrun  out  1  one-cycle pulse when a frame is aborted for lack of data.

Behaviour:
- Reset (async):
  - All outputs 0, state IDLE.
  - CRC register = 0xFFFFFFFF; counters cleared.
  - A reset mid-frame drops mii_tx_en immediately. No FCS or IFG is produced after reset.
- All outputs are registered.
- States: IDLE, PRE, DATA, PAD, FCS, IFG.
- IDLE:
  - mii_tx_en=0, mii_txd=0, s_ready=0, busy=0.
  - s_valid=1 -> PRE on the next edge. busy goes high on that edge.
- PRE:
  - 16 cycles with mii_tx_en=1.
  - mii_txd = 0x5 for cycles 0-14 and 0xD for cycle 15, i.e. bytes 55x7, D5.
  - s_ready=1 only during cycle 15: the first byte is accepted there.
  - If s_valid=0 in cycle 15 -> underrun.
- DATA:
  - Each byte takes 2 cycles: low nibble, then high nibble.
  - s_ready=1 only during the high-nibble cycle, when the next byte is fetched, and only if the current byte was not last.
  - The byte handshake gives back-to-back bytes with no gap.
  - Byte counter increments per byte and saturates at MIN_BYTES.
- Byte accepted with s_last=1: after its high nibble, the next state is:
  - PAD, if PAD_EN and count < MIN_BYTES;
  - otherwise FCS.
- PAD: emit 0x0 nibbles, 2 per byte, until count = MIN_BYTES, then FCS. s_ready=0.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Updated per transmitted nibble, LSB first, over data and pad nibbles only.
  - FCS = ~CRC, sent as 8 nibbles starting at bits [3:0] and ending at [31:28].
  - The nibble update is combinational in the same cycle.
- FCS: 8 cycles with mii_tx_en=1, then IFG.
- IFG:
  - IFG_CYCLES cycles with mii_tx_en=0, mii_txd=0, s_ready=0, busy=1.
  - Then IDLE. The CRC is reinitialised on entry to IFG.
- Underrun:
  - s_valid=0 in a cycle where s_ready=1 (PRE cycle 15 or a DATA high-nibble cycle).
  - Next edge: mii_tx_en=0, underrun pulses for 1 cycle, state IFG.
  - No FCS is sent, and no further bytes are accepted for that frame.
- s_valid while busy: ignored (s_ready=0) until IDLE is re-entered.
  - The first possible new frame starts at the IDLE cycle immediately after IFG.
- Frame length on the wire, in mii_tx_en cycles: 16 + 2·max(N, PAD_EN ? MIN_BYTES : N) + 8.

Test Plan:
- CRC check (PAD_EN=0): send ASCII "123456789" back-to-back.
  - Expected: 16 preamble nibbles (5×15, D).
  - Then nibbles 1,3,2,3,…,9,3.
  - Then FCS nibbles 6,2,9,3,4,F,B,C (bytes 26 39 F4 CB).
  - mii_tx_en high exactly 42 cycles, then 24 low.
- Padding (PAD_EN=1): send a 10-byte frame.
  - 100 zero nibbles follow the data.
  - mii_tx_en high 16+120+8 = 144 cycles.
  - The FCS must match a software CRC over 10 data bytes + 50 zero bytes.
- Underrun: drop s_valid at the 5th byte's fetch slot.
  - mii_tx_en falls the next cycle; underrun pulses once; no FCS nibbles.
  - busy stays high 24 more cycles, then IDLE.
- Back-to-back frames: hold s_valid with a second frame queued.
  - Exactly 24 mii_tx_en-low cycles plus 1 IDLE cycle separate the frames.
  - The second preamble is intact.
- Reset mid-DATA: assert reset asynchronously.
  - mii_tx_en, s_ready and busy go to 0 without waiting for a clock edge.
  - After release, a new 9-byte frame reproduces the CRC-check output exactly.
- s_ready timing: check s_ready is high only on PRE cycle 15 and on DATA high-nibble cycles.
  - Check s_ready is never high after s_last is accepted.
